sop_vector_sequencer: RTL

Sequencer and checker for the 5-input gate-level sum-of-products datapath, y = (a·b'·c') + (a·b·e) + (b'·c) + (c·d'). It accepts operand vectors over a valid/ready handshake and drives them onto the datapath operand bus. It then waits a programmable settle time covering the worst-case gate delays, samples y, and reports the result. With checking compiled in, it also compares y against an internal golden model and keeps pass/fail counts.

---
 rtl/sop_seq_pkg.sv | 30 +++
 rtl/sop_vector_sequencer_timer.sv | 29 ++
 rtl/sop_vector_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sop_seq_pkg.sv
// Shared types and helpers for the SOP datapath sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sop_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Operand bit positions on the {a,b,c,d,e} bus.
  localparam int A_IDX = 4;
  localparam int B_IDX = 3;
  localparam int C_IDX = 2;
  localparam int D_IDX = 1;
  localparam int E_IDX = 0;

  // Reference value of y = a.b'.c' + a.b.e + b'.c + c.d'
  function automatic logic sop_golden(input logic [4:0] vec);
    logic a, b, c, d, e;
    a = vec[A_IDX];
    b = vec[B_IDX];
    c = vec[C_IDX];
    d = vec[D_IDX];
    e = vec[E_IDX];
    return (a & ~b & ~c) | (a & b & e) | (~b & c) | (c & ~d);
  endfunction

endpackage

// File: rtl/sop_vector_sequencer_timer.sv
// Loadable settle down-counter; done flags the final settle cycle (value == 1).
// Latency: load takes effect on the next edge; one decrement per enabled edge.
// Backpressure: none; the sequencer enables it only while settling.
module sop_settle_timer #(
  parameter int SETTLE_CYCLES = 4,
  localparam int W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         done
);

  // Load has priority so a fresh vector always restarts the full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= W'(SETTLE_CYCLES);
    end else if (en) begin
      value <= value - W'(1);
    end
  end

  assign done = (value == W'(1));

endmodule

// File: rtl/sop_vector_sequencer.sv
// Drives operand vectors to the SOP datapath, samples y after a settle window, reports it.
// Latency: result valid SETTLE_CYCLES edges after acceptance; one vector per SETTLE_CYCLES+2 cycles.
// Backpressure: result held until out_ready; in_ready low whenever a vector is in flight. Checker: SOP_SEQ_CHECK_EN.
module sop_vector_sequencer
  import sop_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_vec,
  output logic [4:0]       dp_abcde,
  input  logic             dp_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_vec,
  output logic             out_y,
  output logic             out_mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  input  logic             clr_cnt,
  output logic             busy
);

  localparam int TW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("sop_vector_sequencer: SETTLE_CYCLES must be at least 1");
  end

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   tmr_value;
  logic            tmr_done;
  logic            accept;
  logic            sample;
  logic            handshake;

  assign accept    = in_valid & in_ready;
  assign sample    = (state == SETTLE) & tmr_done;
  assign handshake = out_valid & out_ready;

  sop_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .en    ((state == SETTLE) && (tmr_value != '0)),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // State register; reset discards any in-flight vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded handshake outputs (in_ready depends on state only).
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (tmr_done) state_nxt = REPORT;
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand bus and result capture; the bus only moves on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_abcde <= '0;
      out_vec  <= '0;
      out_y    <= 1'b0;
    end else begin
      if (accept) begin
        dp_abcde <= in_vec;
        out_vec  <= in_vec;
      end
      if (sample) begin
        out_y <= dp_y;
      end
    end
  end

  // Pass counter: saturating, clear wins over a coincident increment.
  logic pass_inc;

`ifdef SOP_SEQ_CHECK_EN
  // Mismatch flag; X/Z on dp_y never equals the golden value so it counts as a miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_mismatch <= 1'b0;
    end else if (sample) begin
      out_mismatch <= (dp_y !== sop_golden(out_vec));
    end
  end

  assign pass_inc = handshake & ~out_mismatch;

  // Fail counter: saturating, clear wins over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt <= '0;
    end else if (clr_cnt) begin
      fail_cnt <= '0;
    end else if (handshake && out_mismatch && (fail_cnt != '1)) begin
      fail_cnt <= fail_cnt + CNT_W'(1);
    end
  end
`else
  assign out_mismatch = 1'b0;
  assign fail_cnt     = '0;
  assign pass_inc     = handshake;
`endif

  // Pass counter update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
    end else if (clr_cnt) begin
      pass_cnt <= '0;
    end else if (pass_inc && (pass_cnt != '1)) begin
      pass_cnt <= pass_cnt + CNT_W'(1);
    end
  end

endmodule
